store_write_buffer: RTL and testbench
=====================================

Name: store_write_buffer

Overview:
- Small FIFO write buffer between the core store port and the banked data-cache write port.
- Absorbs core stores while the memory controller occupies the target cache bank, so the core does not stall on the bank-busy signal.
- Merges back-to-back stores to the same word.
- Provides byte-granular store-to-load forwarding for buffered stores.

Parameters:
- DEPTH, 4, number of buffer entries (power of two, ≥2).
- ADDR_W, 30, word-address width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low (asserted = 0).
- IN_we  input  1  core store request, active-low.
- IN_wmask  input  4  byte mask of the store.
- IN_waddr  input  ADDR_W  word address of the store.
- IN_wdata  input  32  store data.
- OUT_full  output  1  buffer full; the core must not present a store.
- OUT_empty  output  1  no buffered stores.
- IN_re  input  1  core load lookup, active-low.
- IN_raddr  input  ADDR_W  load word address.
- OUT_fwdMask  output  4  bytes that can be forwarded.
- OUT_fwdData  output  32  forwarded bytes; bytes whose mask bit is 0 are don't-care.
- OUT_CACHE_ce  output  1  cache port enable, active-low.
- OUT_CACHE_we  output  1  cache write enable, active-low.
- OUT_CACHE_wm  output  4  cache byte write mask.
- OUT_CACHE_addr  output  ADDR_W  cache word address; bit 0 selects the bank.
- OUT_CACHE_data  output  32  cache write data.
- IN_CACHE_busy  input  1  target bank owned by the memory controller this cycle; derived combinationally from OUT_CACHE_addr[0].

Behaviour:
- Reset (rst=0, asynchronous):
  - Head, tail and count are 0.
  - OUT_CACHE_ce=1, OUT_CACHE_we=1, OUT_full=0, OUT_empty=1, OUT_fwdMask=0.
  - Entry contents are don't-care.
  - Any in-flight store is discarded; no write is issued after reset deasserts until a new store arrives.
- Storage: circular FIFO of {addr, mask, data}; count ranges 0..DEPTH.
  - OUT_full = (count==DEPTH).
  - OUT_empty = (count==0).
  - Both are driven from registers only.
- Drain (head issue):
  - When count>0, OUT_CACHE_ce=0 and OUT_CACHE_we=0, with wm/addr/data taken from the head entry. Otherwise ce=we=1 and the other cache outputs are 0.
  - A write completes in any cycle where ce=0 and IN_CACHE_busy=0. The head pops at that clock edge.
  - While IN_CACHE_busy=1, all cache outputs stay stable and nothing pops.
- Enqueue:
  - A store is accepted when IN_we=0 and count<DEPTH.
  - A store presented while full is ignored, with no state change. This is a protocol violation; the bench must flag it.
  - Minimum latency: a store accepted at edge N is presented on the cache port in cycle N+1.
- Coalescing:
  - Applies when IN_we=0, count>0 and IN_waddr equals the tail-1 (youngest) entry address.
  - Exception: no coalescing when that entry is the head and is popping this cycle (count==1, ce=0, busy=0). In that case the store allocates normally.
  - On merge: each byte with IN_wmask bit set is overwritten by IN_wdata; new mask = old mask OR IN_wmask; count is unchanged.
  - Coalescing applies even when the buffer is full.
- Simultaneous pop and enqueue (non-coalescing): count is unchanged. Accepted even when full, because the pop frees a slot in the same cycle.
- Forwarding (combinational, registered entries only):
  - For each byte b, select the youngest valid entry with addr==IN_raddr and mask[b]=1. Set OUT_fwdMask[b]=1 and OUT_fwdData byte b from that entry.
  - OUT_fwdMask=0 when IN_re=1.
  - The incoming same-cycle store is excluded.
  - An entry popping this cycle is still included.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH or underflows.

Test Plan:
- Single store, busy=0: IN_we=0, addr 0x10, mask 1111, data 0xAABBCCDD at edge N -> cycle N+1: ce=we=0, addr 0x10, data 0xAABBCCDD; after edge N+1, OUT_empty=1 and ce=1.
- Busy stall: one entry at addr 0x11 with busy=1 for 3 cycles -> cache outputs held identical for 3 cycles; pop on the first cycle with busy=0.
- Fill/overflow: busy=1, stores to addr 0x1,0x2,0x3,0x4 -> OUT_full=1; a 5th store to 0x5 is ignored; on busy=0 the writes drain in order 0x1..0x4 over 4 cycles and the 0x5 data never appears.
- Coalesce: busy=1; store addr 0x20, mask 0001, data 0x00000011; then addr 0x20, mask 0100, data 0x00220000 -> count=1; written entry has mask 0101, data bytes 2,0 = 0x22,0x11.
- Forwarding: busy=1; store 0x30 mask 1111 data 0x01020304; store 0x31 mask 1111; store 0x30 mask 0010 data 0x0000AA00; IN_re=0, raddr 0x30 -> fwdMask 1111, fwdData 0x0102AA04. raddr 0x40 -> fwdMask 0000.
- Reset mid-operation: 3 entries buffered with busy=1; drive rst=0 asynchronously between edges -> ce=1, OUT_empty=1 immediately; after rst=1 and busy=0, no write is issued.

Source files
------------

// File: rtl/store_write_buffer.sv
// Store write buffer: FIFO between the core store port and the banked data-cache
// write port, with youngest-entry store coalescing and byte-granular load forwarding.
module store_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IN_we,
  input  logic [3:0]        IN_wmask,
  input  logic [ADDR_W-1:0] IN_waddr,
  input  logic [31:0]       IN_wdata,
  output logic              OUT_full,
  output logic              OUT_empty,
  input  logic              IN_re,
  input  logic [ADDR_W-1:0] IN_raddr,
  output logic [3:0]        OUT_fwdMask,
  output logic [31:0]       OUT_fwdData,
  output logic              OUT_CACHE_ce,
  output logic              OUT_CACHE_we,
  output logic [3:0]        OUT_CACHE_wm,
  output logic [ADDR_W-1:0] OUT_CACHE_addr,
  output logic [31:0]       OUT_CACHE_data,
  input  logic              IN_CACHE_busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;
  localparam logic [PTR_W:0]   CNT_MAX = DEPTH;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [3:0]        r_mask [DEPTH];
  logic [31:0]       r_data [DEPTH];
  logic [PTR_W-1:0]  r_head, r_tail;
  logic [PTR_W:0]    r_count;
  logic              r_full, r_empty;

  logic [PTR_W-1:0]  w_youngest;
  logic              w_pop, w_coalesce, w_push;
  logic [PTR_W:0]    w_count_next;

  assign w_youngest = r_tail - PTR_ONE;
  assign w_pop      = !r_empty && !IN_CACHE_busy;
  // A lone head that is leaving this cycle cannot absorb a merge; the store allocates instead.
  assign w_coalesce = !IN_we && !r_empty && (r_addr[w_youngest] == IN_waddr)
                      && !((r_count == CNT_ONE) && w_pop);
  assign w_push     = !IN_we && !w_coalesce && (!r_full || w_pop);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)      w_count_next = r_count + CNT_ONE;
    else if (!w_push && w_pop) w_count_next = r_count - CNT_ONE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_pop)  r_head <= r_head + PTR_ONE;
      if (w_push) r_tail <= r_tail + PTR_ONE;
      r_count <= w_count_next;
      r_full  <= (w_count_next == CNT_MAX);
      r_empty <= (w_count_next == '0);
    end
  end

  // NOTE: entry storage is deliberately not reset; validity comes only from head/count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= IN_waddr;
      r_mask[r_tail] <= IN_wmask;
      r_data[r_tail] <= IN_wdata;
    end else if (w_coalesce) begin
      r_mask[w_youngest] <= r_mask[w_youngest] | IN_wmask;
      for (int b = 0; b < 4; b++) begin
        if (IN_wmask[b]) r_data[w_youngest][8*b +: 8] <= IN_wdata[8*b +: 8];
      end
    end
  end

  assign OUT_full       = r_full;
  assign OUT_empty      = r_empty;
  assign OUT_CACHE_ce   = r_empty;
  assign OUT_CACHE_we   = r_empty;
  assign OUT_CACHE_wm   = r_empty ? '0 : r_mask[r_head];
  assign OUT_CACHE_addr = r_empty ? '0 : r_addr[r_head];
  assign OUT_CACHE_data = r_empty ? '0 : r_data[r_head];

  // Walk oldest to youngest so later matches override earlier ones per byte.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx         = '0;
    OUT_fwdMask = '0;
    OUT_fwdData = '0;
    if (!IN_re) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = r_head + PTR_W'(i);
        if ((i < int'(r_count)) && (r_addr[idx] == IN_raddr)) begin
          for (int b = 0; b < 4; b++) begin
            if (r_mask[idx][b]) begin
              OUT_fwdMask[b]          = 1'b1;
              OUT_fwdData[8*b +: 8]   = r_data[idx][8*b +: 8];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed test-plan steps followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_store_write_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 30;

  logic              clk = 1'b0;
  logic              rst;
  logic              we_n, re_n;
  logic [3:0]        wmask;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [31:0]       wdata;
  logic [1:0]        bank_busy;
  logic              busy;
  logic              full, empty, c_ce, c_we;
  logic [3:0]        fwd_mask, c_wm;
  logic [31:0]       fwd_data, c_data;
  logic [ADDR_W-1:0] c_addr;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        mask;
    logic [31:0]       data;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   viol   = 0;

  always #5 clk = ~clk;
  assign busy = bank_busy[c_addr[0]];

  store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .IN_we(we_n), .IN_wmask(wmask), .IN_waddr(waddr), .IN_wdata(wdata),
    .OUT_full(full), .OUT_empty(empty),
    .IN_re(re_n), .IN_raddr(raddr),
    .OUT_fwdMask(fwd_mask), .OUT_fwdData(fwd_data),
    .OUT_CACHE_ce(c_ce), .OUT_CACHE_we(c_we), .OUT_CACHE_wm(c_wm),
    .OUT_CACHE_addr(c_addr), .OUT_CACHE_data(c_data),
    .IN_CACHE_busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bytes_of(input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

  // Compare every DUT output against the model's view of the buffer.
  task automatic check_model();
    logic [3:0]  em;
    logic [31:0] ed;
    em = '0;
    ed = '0;
    check("full",  full,  q.size() == DEPTH);
    check("empty", empty, q.size() == 0);
    check("ce",    c_ce,  q.size() == 0);
    check("we",    c_we,  q.size() == 0);
    check("wm",    c_wm,   q.size() ? q[0].mask : 4'h0);
    check("addr",  c_addr, q.size() ? q[0].addr : '0);
    check("data",  c_data, q.size() ? q[0].data : 32'h0);
    if (!re_n) begin
      for (int b = 0; b < 4; b++) begin
        for (int k = q.size() - 1; k >= 0; k--) begin
          if (q[k].addr == raddr && q[k].mask[b]) begin
            em[b]          = 1'b1;
            ed[8*b +: 8]   = q[k].data[8*b +: 8];
            break;
          end
        end
      end
    end
    check("fwd_mask", fwd_mask, em);
    check("fwd_data", fwd_data & bytes_of(em), ed);
  endtask

  // Apply the buffer rules to the model for one clock edge.
  task automatic model_edge();
    logic pop, coal;
    pop  = (q.size() > 0) && !bank_busy[q[0].addr[0]];
    coal = 1'b0;
    if (!we_n) begin
      coal = (q.size() > 0) && (q[$].addr == waddr) && !(q.size() == 1 && pop);
      if (coal) begin
        for (int b = 0; b < 4; b++)
          if (wmask[b]) q[$].data[8*b +: 8] = wdata[8*b +: 8];
        q[$].mask = q[$].mask | wmask;
      end
    end
    if (!we_n && !coal && !(q.size() < DEPTH || pop)) begin
      viol++;
      $display("protocol violation: store to %h presented while full at %0t", waddr, $time);
    end
    if (!we_n && !coal && (q.size() < DEPTH || pop)) begin
      if (pop) void'(q.pop_front());
      q.push_back('{addr: waddr, mask: wmask, data: wdata});
    end else if (pop) begin
      void'(q.pop_front());
    end
  endtask

  task automatic step(input logic w, input logic [3:0] m, input logic [ADDR_W-1:0] a,
                      input logic [31:0] d, input logic r, input logic [ADDR_W-1:0] ra,
                      input logic [1:0] bb);
    we_n = w; wmask = m; waddr = a; wdata = d;
    re_n = r; raddr = ra; bank_busy = bb;
    #1;
    check_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic store(input logic [ADDR_W-1:0] a, input logic [3:0] m,
                       input logic [31:0] d, input logic [1:0] bb);
    step(1'b0, m, a, d, 1'b1, '0, bb);
  endtask

  task automatic idle(input logic [1:0] bb);
    step(1'b1, 4'h0, '0, 32'h0, 1'b1, '0, bb);
  endtask

  initial begin
    rst = 1'b0;
    we_n = 1'b1; re_n = 1'b0; wmask = '0; waddr = '0; wdata = '0;
    raddr = '0; bank_busy = 2'b00;
    @(negedge clk);
    #1;
    check("rst_ce", c_ce, 1'b1);
    check("rst_we", c_we, 1'b1);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_fwd", fwd_mask, 4'h0);
    @(negedge clk);
    rst = 1'b1;

    // Single store drains the next cycle.
    store(30'h10, 4'hf, 32'hAABBCCDD, 2'b00);
    check("t1_ce", c_ce, 1'b0);
    check("t1_addr", c_addr, 30'h10);
    check("t1_data", c_data, 32'hAABBCCDD);
    idle(2'b00);
    check("t1_empty", empty, 1'b1);
    check("t1_ce_after", c_ce, 1'b1);

    // Busy stall holds the port, then pops.
    store(30'h11, 4'hf, 32'h12345678, 2'b11);
    for (int i = 0; i < 3; i++) begin
      check("t2_hold_addr", c_addr, 30'h11);
      check("t2_hold_data", c_data, 32'h12345678);
      idle(2'b11);
    end
    idle(2'b00);
    check("t2_empty", empty, 1'b1);

    // Fill, overflow attempt, ordered drain.
    for (int k = 1; k <= 4; k++) store(30'(k), 4'hf, 32'h1000 + k, 2'b11);
    check("t3_full", full, 1'b1);
    store(30'h5, 4'hf, 32'hDEAD0005, 2'b11);
    check("t3_viol", viol, 1);
    check("t3_still_full", full, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      check("t3_drain_addr", c_addr, 30'(k));
      idle(2'b00);
    end
    check("t3_drained", empty, 1'b1);

    // Coalescing into one entry.
    store(30'h20, 4'b0001, 32'h00000011, 2'b11);
    store(30'h20, 4'b0100, 32'h00220000, 2'b11);
    check("t4_wm", c_wm, 4'b0101);
    check("t4_data", c_data & 32'h00FF00FF, 32'h00220011);
    idle(2'b00);
    check("t4_single", empty, 1'b1);

    // Forwarding from the youngest matching entries.
    store(30'h30, 4'hf, 32'h01020304, 2'b11);
    store(30'h31, 4'hf, 32'h99999999, 2'b11);
    store(30'h30, 4'b0010, 32'h0000AA00, 2'b11);
    we_n = 1'b1; re_n = 1'b0; raddr = 30'h30;
    #1;
    check("t5_fwd_mask", fwd_mask, 4'hf);
    check("t5_fwd_data", fwd_data, 32'h0102AA04);
    step(1'b1, 4'h0, '0, 32'h0, 1'b0, 30'h40, 2'b11);
    for (int i = 0; i < 3; i++) idle(2'b00);
    check("t5_empty", empty, 1'b1);

    // Asynchronous reset between edges discards buffered stores.
    for (int k = 0; k < 3; k++) store(30'h50 + 30'(k), 4'hf, 32'h5000 + k, 2'b11);
    #2 rst = 1'b0;
    #1;
    check("t6_ce", c_ce, 1'b1);
    check("t6_empty", empty, 1'b1);
    q.delete();
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) idle(2'b00);

    // Randomized traffic over a small address window to exercise merges and forwarding.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 1) == 0) ? 1'b0 : 1'b1,
           4'($urandom_range(0, 15)),
           30'($urandom_range(0, 7)),
           $urandom,
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
           30'($urandom_range(0, 7)),
           {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)});
    end
    for (int i = 0; i < DEPTH + 1; i++) idle(2'b00);
    check("final_empty", empty, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
